cassette_fsk_player: RTL

- Tape playback engine between the SDRAM tape image and the MC-10 cassette input (cin).
- Reads the downloaded .k7 image byte by byte from SDRAM.
- Serialises each byte LSB-first as one full square-wave cycle per bit: '0' at FREQ0, '1' at FREQ1.
- OSD controls: play/pause toggle and rewind. Also reports a playing status for LED use.

---
 rtl/cassette_fsk_player.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cassette_fsk_player.sv
// Tape playback engine: streams a .k7 image from SDRAM to the cassette input
// as FSK, one full square-wave cycle per bit, LSB first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped or paused; data low, tone counters frozen
// FETCH  | one-cycle read strobe at entry, wait RD_LAT, latch the byte
// TONE   | emitting bits: high for HALF cycles, then low for HALF cycles
// END    | image exhausted; waits for rewind
module cassette_fsk_player #(
   parameter int CLK_HZ = 28_636_363,
   parameter int FREQ0  = 1200,
   parameter int FREQ1  = 2400,
   parameter int RD_LAT = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        play,
   input  logic        rewind,
   input  logic [24:0] tape_len,
   output logic [24:0] sdram_addr,
   output logic        sdram_rd,
   input  logic [7:0]  sdram_data,
   output logic        data,
   output logic        playing
);

   localparam int HALF0 = CLK_HZ / (2 * FREQ0);
   localparam int HALF1 = CLK_HZ / (2 * FREQ1);
   localparam int CW    = $clog2(HALF0 + 1);
   localparam int LW    = $clog2(RD_LAT + 1);

   localparam logic [CW-1:0] H0_TC  = CW'(HALF0 - 1);
   localparam logic [CW-1:0] H1_TC  = CW'(HALF1 - 1);
   localparam logic [LW-1:0] LAT_LD = LW'(RD_LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_TONE  = 2'd2,
      S_END   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic          play_d, rew_d;
   logic [24:0]   addr;
   logic [2:0]    bit_idx;
   logic [CW-1:0] half_cnt;
   logic          phase;
   logic [7:0]    shift;
   logic [7:0]    nxt_byte;
   logic          nxt_vld;
   logic          loaded;
   logic [LW-1:0] lat_cnt;
   logic          pf_busy;
   logic [LW-1:0] pf_cnt;
   logic          rd_q, rd_pf;
   logic          pause_pend;
   logic          playing_q;

   logic play_req, rew_req, tape_empty, has_more;
   logic half_done, bit_end, byte_end, lat_done;
   logic start_fetch, fetch_latch, tone_run, pause_nxt;

   function automatic logic [CW-1:0] half_tc(input logic b);
      return b ? H1_TC : H0_TC;
   endfunction

   assign play_req   = play & ~play_d;
   assign rew_req    = rewind & ~rew_d;
   assign tape_empty = (tape_len == '0);
   assign has_more   = (({1'b0, addr} + 26'd1) < {1'b0, tape_len});
   assign half_done  = (half_cnt == '0);
   assign bit_end    = half_done & phase;
   assign byte_end   = bit_end & (bit_idx == 3'd7);
   assign lat_done   = (lat_cnt == '0);

   always_ff @(posedge clk_sys) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_fetch = 1'b0;
      fetch_latch = 1'b0;
      tone_run    = 1'b0;
      pause_nxt   = 1'b0;
      if (rew_req) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (play_req && !tape_empty) begin
                  if (loaded) begin
                     state_nxt = S_TONE;
                  end else begin
                     state_nxt   = S_FETCH;
                     start_fetch = 1'b1;
                  end
               end
            end
            S_FETCH: begin
               // a pause during a fetch lets the latch complete before stopping
               pause_nxt = pause_pend | play_req;
               if (lat_done) begin
                  fetch_latch = 1'b1;
                  state_nxt   = pause_nxt ? S_IDLE : S_TONE;
                  pause_nxt   = 1'b0;
               end
            end
            S_TONE: begin
               tone_run = 1'b1;
               if (byte_end && !has_more) begin
                  state_nxt = S_END;
               end else if (byte_end && !nxt_vld) begin
                  state_nxt   = play_req ? S_IDLE : S_FETCH;
                  start_fetch = ~play_req;
               end else if (play_req) begin
                  state_nxt = S_IDLE;
               end
            end
            S_END: begin
               state_nxt = S_END;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         play_d     <= 1'b0;
         rew_d      <= 1'b0;
         addr       <= '0;
         bit_idx    <= '0;
         half_cnt   <= '0;
         phase      <= 1'b0;
         shift      <= '0;
         nxt_byte   <= '0;
         nxt_vld    <= 1'b0;
         loaded     <= 1'b0;
         lat_cnt    <= '0;
         pf_busy    <= 1'b0;
         pf_cnt     <= '0;
         rd_q       <= 1'b0;
         rd_pf      <= 1'b0;
         pause_pend <= 1'b0;
         playing_q  <= 1'b0;
      end else begin
         play_d     <= play;
         rew_d      <= rewind;
         rd_q       <= 1'b0;
         rd_pf      <= 1'b0;
         pause_pend <= pause_nxt;
         playing_q  <= (state_nxt == S_TONE) || ((state_nxt == S_FETCH) && !pause_nxt);
         if (rew_req) begin
            addr     <= '0;
            bit_idx  <= '0;
            half_cnt <= '0;
            phase    <= 1'b0;
            loaded   <= 1'b0;
            nxt_vld  <= 1'b0;
            pf_busy  <= 1'b0;
            pf_cnt   <= '0;
            lat_cnt  <= '0;
         end else begin
            // prefetch keeps counting while paused so its data is never lost
            if (pf_busy) begin
               if (pf_cnt == '0) begin
                  pf_busy  <= 1'b0;
                  nxt_byte <= sdram_data;
                  nxt_vld  <= 1'b1;
               end else begin
                  pf_cnt <= pf_cnt - LW'(1);
               end
            end
            if (start_fetch) begin
               rd_q    <= 1'b1;
               lat_cnt <= LAT_LD;
            end
            if ((state == S_FETCH) && !lat_done) lat_cnt <= lat_cnt - LW'(1);
            if (fetch_latch) begin
               shift    <= sdram_data;
               loaded   <= 1'b1;
               bit_idx  <= '0;
               phase    <= 1'b0;
               half_cnt <= half_tc(sdram_data[0]);
            end
            if (tone_run) begin
               if (!half_done) begin
                  half_cnt <= half_cnt - CW'(1);
               end else if (!phase) begin
                  phase    <= 1'b1;
                  half_cnt <= half_tc(shift[bit_idx]);
               end else begin
                  phase   <= 1'b0;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx != 3'd7) begin
                     half_cnt <= half_tc(shift[bit_idx + 3'd1]);
                  end else if (has_more && nxt_vld) begin
                     addr     <= addr + 25'd1;
                     shift    <= nxt_byte;
                     nxt_vld  <= 1'b0;
                     half_cnt <= half_tc(nxt_byte[0]);
                  end else if (has_more) begin
                     addr   <= addr + 25'd1;
                     loaded <= 1'b0;
                  end
                  if ((bit_idx == 3'd6) && has_more) begin
                     rd_q    <= 1'b1;
                     rd_pf   <= 1'b1;
                     pf_busy <= 1'b1;
                     pf_cnt  <= LAT_LD;
                  end
               end
            end
         end
      end
   end

   assign sdram_rd   = rd_q;
   assign sdram_addr = rd_pf ? (addr + 25'd1) : addr;
   assign data       = (state == S_TONE) && !phase;
   assign playing    = playing_q;

endmodule
